// File: rtl/shifter_pkg.sv
// Shared definitions for the sequential shifter family: FSM encoding and
// default operand/shift-amount widths.
package shifter_pkg;

  localparam int SHIFTER_N = 11;
  localparam int SHIFTER_S = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shifter_state_t;

endpackage

// File: rtl/shift_reg_sll.sv
// N-bit data register with synchronous load and a shift-left-by-one enable.
// Load wins over shift; the LSB is zero-filled on every shift.
module shift_reg_sll #(
  parameter int N = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift_en,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] q
);

  logic [N-1:0] data_q;
  logic [N-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = load_val;
    end else if (shift_en) begin
      data_d = {data_q[N-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/shifter_sll_seq.sv
// Multi-cycle logical left shifter: one bit per clock through a single
// N-bit register, with valid/ready handshakes on request and result.
module shifter_sll_seq
  import shifter_pkg::*;
#(
  parameter int N = SHIFTER_N,
  parameter int S = SHIFTER_S
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [S-1:0] in_s,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_y,
  output logic         busy
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // ready/valid outputs decode from state only, never from the partner's strobe.

  localparam logic [S-1:0] N_S = S'(N);

  shifter_state_t state_q, state_d;
  logic [S-1:0]   count_q, count_d;
  logic [N-1:0]   y_q, y_d;
  logic [N-1:0]   data;
  logic [S-1:0]   s_clamped;
  logic           accept;
  logic           shift_en;
  logic           finish;

  assign s_clamped = (in_s >= N_S) ? N_S : in_s;
  assign accept    = (state_q == IDLE) && in_valid;
  assign shift_en  = (state_q == SHIFT) && (count_q != '0);
  assign finish    = (state_q == SHIFT) && (count_q == '0);

  shift_reg_sll #(.N(N)) u_data (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .shift_en (shift_en),
    .load_val (in_a),
    .q        (data)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = SHIFT;
      SHIFT:   if (count_q == '0) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (accept) begin
      count_d = s_clamped;
    end else if (shift_en) begin
      count_d = count_q - 1'b1;
    end
  end

  // Result is captured once on entry to DONE so out_y never shows
  // intermediate shift values while the data register is working.
  always_comb begin
    y_d = y_q;
    if (finish) begin
      y_d = data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      y_q     <= '0;
    end else begin
      count_q <= count_d;
      y_q     <= y_d;
    end
  end

  assign out_y = y_q;

endmodule

// File: tb/tb_shifter_sll_seq.sv
// Self-checking bench for shifter_sll_seq: directed scenarios plus a random
// regression scored against a shift model through an expected-result queue.
module tb_shifter_sll_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [10:0] in_a = '0;
  logic [3:0]  in_s = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [10:0] out_y;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [10:0] exp_q[$];
  int          lat_q[$];
  logic [10:0] last_y = '0;

  shifter_sll_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_s      (in_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .busy      (busy)
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic logic [10:0] model_y(input logic [10:0] a, input logic [3:0] s);
    logic [10:0] r;
    r = a << s;
    return r;
  endfunction

  function automatic int model_k(input logic [3:0] s);
    return (s > 4'd11) ? 11 : int'(s);
  endfunction

  // Driver: one full request/result transaction with optional DONE stall
  // and an optional ignored in_valid pulse during the stall.
  task automatic run_op(input logic [10:0] a, input logic [3:0] s,
                        input int stall, input logic poke);
    int edges;
    int busy_cnt;
    int held;
    int lat;
    int exp_lat;
    int exp_busy;
    logic seen;
    logic done_ok;
    logic [10:0] exp_y;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL in_ready_idle: got %b want 1", in_ready);
    end
    in_a = a;
    in_s = s;
    in_valid = 1'b1;
    out_ready = (stall == 0);
    exp_q.push_back(model_y(a, s));
    lat_q.push_back(model_k(s) + 1);
    exp_busy = model_k(s) + 1 + ((stall > 0) ? stall : 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = 11'($urandom);
    in_s = 4'($urandom);
    edges = 0; busy_cnt = 0; held = 0; lat = 0; exp_lat = 0;
    seen = 1'b0; done_ok = 1'b0; exp_y = '0;
    while (edges < 60) begin
      @(negedge clk);
      if (out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          lat = edges;
          if (exp_q.size() > 0) begin
            exp_y = exp_q.pop_front();
            exp_lat = lat_q.pop_front();
          end
          n_cmp++;
          if (out_y !== exp_y) begin
            n_err++;
            $display("FAIL result a=%h s=%0d: got %h want %h", a, s, out_y, exp_y);
          end
          n_cmp++;
          if (lat != exp_lat) begin
            n_err++;
            $display("FAIL latency a=%h s=%0d: got %0d want %0d", a, s, lat, exp_lat);
          end
          last_y = exp_y;
        end else begin
          n_cmp++;
          if (out_y !== exp_y) begin
            n_err++;
            $display("FAIL y_hold: got %h want %h", out_y, exp_y);
          end
        end
        n_cmp++;
        if (in_ready !== 1'b0) begin
          n_err++;
          $display("FAIL in_ready_done: got %b want 0", in_ready);
        end
        if (!out_ready) begin
          held++;
          if (poke) in_valid = (held == 2);
          if (held >= stall) begin
            in_valid = 1'b0;
            out_ready = 1'b1;
          end
        end
      end else if (busy) begin
        n_cmp++;
        if (out_y !== last_y) begin
          n_err++;
          $display("FAIL y_during_shift: got %h want %h", out_y, last_y);
        end
      end
      if (busy) begin
        busy_cnt++;
      end else if (seen) begin
        done_ok = 1'b1;
        break;
      end
      @(posedge clk);
      edges++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (!seen || !done_ok) begin
      n_err++;
      $display("FAIL timeout a=%h s=%0d: seen=%b idle=%b", a, s, seen, done_ok);
    end
    n_cmp++;
    if (busy_cnt != exp_busy) begin
      n_err++;
      $display("FAIL busy_cycles a=%h s=%0d: got %0d want %0d", a, s, busy_cnt, exp_busy);
    end
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      n_err++;
      $display("FAIL reset_flags: got rdy/vld/busy=%b want 100", {in_ready, out_valid, busy});
    end
    n_cmp++;
    if (out_y !== 11'h000) begin
      n_err++;
      $display("FAIL reset_y: got %h want 000", out_y);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_y = '0;
  endtask

  task automatic test_basic();
    run_op(11'h001, 4'd3, 0, 1'b0);
  endtask

  task automatic test_zero_shift();
    run_op(11'h5A5, 4'd0, 0, 1'b0);
  endtask

  task automatic test_clamp();
    run_op(11'h7FF, 4'd10, 0, 1'b0);
    run_op(11'h7FF, 4'd11, 0, 1'b0);
    run_op(11'h7FF, 4'd15, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_op(11'h2B7, 4'd5, 6, 1'b1);
    @(negedge clk);
    n_cmp++;
    if ({busy, out_valid, in_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL poke_ignored: got busy/vld/rdy=%b want 001", {busy, out_valid, in_ready});
    end
    run_op(11'h123, 4'd4, 0, 1'b0);
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    in_a = 11'h0F0;
    in_s = 4'd8;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      n_err++;
      $display("FAIL abort_flags: got rdy/vld/busy=%b want 100", {in_ready, out_valid, busy});
    end
    n_cmp++;
    if (out_y !== 11'h000) begin
      n_err++;
      $display("FAIL abort_y: got %h want 000", out_y);
    end
    last_y = '0;
    out_ready = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    run_op(11'h003, 4'd2, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      run_op(11'h001 << i, 4'(i * 3), 0, 1'b0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      run_op(11'($urandom), 4'($urandom_range(0, 15)),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_shift();
    test_clamp();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shifter_sll_seq.md
# shifter_sll_seq

Multi-cycle shift-left-logical unit. It accepts an N-bit operand and a shift amount over a valid/ready handshake. It shifts the operand left one bit per clock, zero-filling the LSB, and presents the result on a second valid/ready handshake. It is the left-direction, area-minimal counterpart to the combinational mux-based logical right shifters. It sits in the datapath beside them and serves callers that can tolerate variable latency in exchange for one N-bit register instead of N muxes.

## Interface
- `N`, 11: operand/result width.
- `S`, 4: shift-amount width; must satisfy 2^S > N.
- `clk`  in  1  rising-edge clock, sole clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request strobe.
- `in_ready`  out  1  unit can accept a request.
- `in_a`  in  N  operand.
- `in_s`  in  S  shift amount, unsigned.
- `out_valid`  out  1  `out_y` holds a result.
- `out_ready`  in  1  consumer takes the result.
- `out_y`  out  N  result, `in_a << in_s` truncated to N bits.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, SHIFT, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready` at an edge: load data reg ← `in_a`, count ← min(`in_s`, N), go to SHIFT.
- **SHIFT**
  - If count==0: go to DONE.
  - Else: data ← {data[N-2:0], 1'b0}, count ← count−1.
- **DONE**
  - `out_valid`=1 and `out_y`=data.
  - On `out_valid`&&`out_ready`: go to IDLE.
  - Until that handshake, `out_y` and `out_valid` are held stable.
- **Clamp:** `in_s` ≥ N clamps to N, so the result is all zeros. Values up to 2^S−1 are legal inputs.
- **Counter width:** the count register is S bits wide and never underflows.
- **No pipelining:** one operation in flight. `in_ready`=0 in SHIFT and DONE, and `in_valid` in those states is ignored (not queued).
- **Combinational outputs:** `in_ready`, `out_valid` and `busy` decode directly from the state register. There is no combinational path from `in_valid` or `out_ready` to any output.
- **Reset values:** state=IDLE, data=0, count=0, `out_valid`=0, `out_y`=0, `busy`=0, `in_ready`=1.
- **Reset mid-operation:** asserting `rst_n` low in SHIFT or DONE aborts immediately. Outputs take their reset values asynchronously, and no partial result is ever presented.
- **Back-to-back:** a result handshake in DONE returns to IDLE. A new request is accepted one edge later at the earliest. `in_ready` is never high in the same cycle as `out_valid`.

## Timing
- Acceptance edge = edge 0. Let k = min(`in_s`, N).
- SHIFT occupies edges 1..k+1. `out_valid` rises after edge k+1, so latency is k+1 cycles: s=0 → 1 cycle, s≥N → N+1 cycles.
- With `out_ready` held high, the DONE→IDLE transition occurs at edge k+2. Throughput is therefore one result per k+3 cycles.
- `out_y` changes only on the transition into DONE and on reset.

## Structure
- Shared package `shifter_pkg`: state enum `shifter_state_t` {IDLE, SHIFT, DONE} and localparam defaults for N and S. Other sequential shifter variants reuse it.
- One sub-module, `shift_reg_sll`: an N-bit register with async active-low reset and synchronous load, plus a shift-left-by-one enable (load has priority).
- The top level holds the FSM, the count register and the clamp comparator.

## Test plan
- **Basic shift:** `in_a`=11'h001, `in_s`=3, `out_ready`=1 → `out_valid` rises 4 cycles after acceptance, `out_y`=11'h008, `busy` is high for 5 cycles.
- **Zero shift:** `in_a`=11'h5A5, `in_s`=0 → `out_y`=11'h5A5 after 1 cycle.
- **Truncation and clamp:** `in_a`=11'h7FF with `in_s`=10 → 11'h400 (latency 11). Same operand with `in_s`=11 and with `in_s`=15 → 11'h000, latency 12 in both cases.
- **Backpressure:** hold `out_ready`=0 for 6 cycles in DONE → `out_y` and `out_valid` stable, `in_ready`=0, and an `in_valid` pulse during that window is ignored. Release `out_ready` → IDLE next edge, and the following request completes correctly.
- **Async reset mid-operation:** pulse `rst_n` low mid-SHIFT (`in_a`=11'h0F0, `in_s`=8), not aligned to `clk` → `out_valid`=0, `out_y`=0, `busy`=0, `in_ready`=1 immediately. A subsequent `in_a`=11'h003, `in_s`=2 yields 11'h00C.
- **Random regression:** 1000 random (`in_a`, `in_s`) pairs with random `out_ready` stalls, checked against the model (`in_a` << `in_s`) & 11'h7FF and against latency min(`in_s`, 11)+1.
